// File: rtl/core_pkg.sv
// Shared definitions for the fetch slice of the single-issue core.
package core_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES      = 4;

  // REQ: request presented; WAIT: awaiting response; HOLD: instruction held for decode;
  // DRAIN: killed request still outstanding, its response will be discarded.
  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: redirect load has priority over sequential increment.
module fetch_pc_reg #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_pc,
  input  logic            i_inc,
  output logic [XLEN-1:0] o_pc
);
  import core_pkg::*;

  logic [XLEN-1:0] r_pc;

  // PC update; the increment wraps silently at the top of the address space.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= {i_load_pc[XLEN-1:2], 2'b00};
    end else if (i_inc) begin
      r_pc <= r_pc + XLEN'(INSTR_BYTES);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem request, valid/ready hand-off to decode,
// execute redirects kill in-flight fetches.
module fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready,
  output logic            busy
);
  import core_pkg::*;

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] w_pc;
  logic            w_rsp_take;
  logic            w_hold_release;
  logic            r_id_valid;
  logic [31:0]     r_id_instr;
  logic [XLEN-1:0] r_id_pc;

  // A response is only kept if no redirect arrives in the same cycle.
  assign w_rsp_take     = (r_state == StWait) && imem_rsp_valid && !redir_valid;
  assign w_hold_release = (r_state == StHold) && (redir_valid || id_ready);

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clock     (clock),
    .reset     (reset),
    .i_load    (redir_valid),
    .i_load_pc (redir_pc),
    .i_inc     (w_rsp_take),
    .o_pc      (w_pc)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StReq;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; redirect overrides the sequential flow in every state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StReq: begin
        // A request accepted under a redirect still completes at the old address.
        if (imem_req_ready) w_state_next = redir_valid ? StDrain : StWait;
      end
      StWait: begin
        if (imem_rsp_valid)   w_state_next = redir_valid ? StReq : StHold;
        else if (redir_valid) w_state_next = StDrain;
      end
      StHold: begin
        if (redir_valid || id_ready) w_state_next = StReq;
      end
      StDrain: begin
        if (imem_rsp_valid) w_state_next = StReq;
      end
      default: w_state_next = StReq;
    endcase
  end

  // Decode-side holding register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else if (w_rsp_take) begin
      r_id_valid <= 1'b1;
      r_id_instr <= imem_rsp_data;
      r_id_pc    <= w_pc;
    end else if (w_hold_release) begin
      r_id_valid <= 1'b0;
    end
  end

  // Outputs; id_valid is masked during a redirect so decode never handshakes a dead instruction.
  always_comb begin
    imem_req_valid = (r_state == StReq);
    imem_req_addr  = w_pc;
    busy           = (r_state == StWait) || (r_state == StDrain);
    id_valid       = r_id_valid && !redir_valid;
    id_instr       = r_id_instr;
    id_pc          = r_id_pc;
  end

endmodule
